// File: rtl/cpu6_shft_seq.sv
// cpu6_shft_seq -- iterative shift sequencer for the cpu6 execute stage.
//
// Computes SLL/SRL/SRA (register and immediate forms) over several cycles
// with a small step-shifter instead of a full barrel shifter. The pipeline
// is stalled through busy while it runs. Completion is signalled by a
// one-cycle done pulse. A flush aborts the operation without a pulse.
//
// Configuration macro: CPU6_SHFT_SEQ_STEP16_EN
//   defined   : step set {16, 4, 1}, worst-case 7 steps
//   undefined : step set {4, 1},     worst-case 10 steps
//   Results are identical in both builds; only latency differs.
//
// Ports:
//   clk     in   core clock, rising edge
//   reset   in   asynchronous, active-low reset
//   start   in   request from the E stage, sampled only in IDLE
//   op      in   [0] right shift, [1] arithmetic (00 SLL, 01 SRL, 11 SRA, 10 = SLL)
//   src     in   operand, sampled with start
//   shamt   in   shift amount, sampled with start
//   flush   in   exception/interrupt flush, aborts any operation
//   busy    out  pipeline stall request (combinational)
//   done    out  one-cycle result-valid pulse (state decode)
//   result  out  registered result, held until the next completion
module cpu6_shft_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src,
  input  logic [4:0]      shamt,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      rem_q, rem_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [1:0]      op_q, op_d;

  logic [4:0]      step;
  logic [XLEN-1:0] shifted;
  logic            right;
  logic            fill;
  logic            busy_raw;

  // Step shifter: pick the largest available step that fits in rem.
  // SRA fills from bit 31 of the work register, which stays equal to the
  // latched sign bit because every arithmetic step replicates it.
  always_comb begin
    right = op_q[0];
    fill  = op_q[0] & op_q[1] & work_q[XLEN-1];
    step  = 5'd1;
    if (rem_q >= 5'd4) step = 5'd4;
`ifdef CPU6_SHFT_SEQ_STEP16_EN
    if (rem_q >= 5'd16) step = 5'd16;
`endif
    case (step)
`ifdef CPU6_SHFT_SEQ_STEP16_EN
      5'd16:   shifted = right ? {{16{fill}}, work_q[31:16]} : {work_q[15:0], 16'b0};
`endif
      5'd4:    shifted = right ? {{4{fill}}, work_q[31:4]} : {work_q[27:0], 4'b0};
      default: shifted = right ? {fill, work_q[31:1]} : {work_q[30:0], 1'b0};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    work_d   = work_q;
    op_d     = op_q;
    busy_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          busy_raw = 1'b1;
          work_d   = src;
          op_d     = op;
          rem_d    = shamt;
          state_d  = (shamt == 5'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy_raw = 1'b1;
        work_d   = shifted;
        rem_d    = rem_q - step;
        if (rem_q == step) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) state_d = IDLE;
  end

  assign busy = reset & busy_raw;
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      work_q  <= '0;
      op_q    <= '0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
      op_q    <= op_d;
      // A flush landing on the DONE cycle must leave result untouched.
      if (state_q == DONE && !flush) result <= work_q;
    end
  end

endmodule

// File: tb/tb_cpu6_shft_seq.sv
module tb_cpu6_shft_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src;
  logic [4:0]  shamt;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  cpu6_shft_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src    (src),
    .shamt  (shamt),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  function automatic int unsigned n_steps(input int unsigned s);
`ifdef CPU6_SHFT_SEQ_STEP16_EN
    return s / 16 + (s % 16) / 4 + s % 4;
`else
    return s / 4 + s % 4;
`endif
  endfunction

  // Align to just after a rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and track busy through completion. When inj > 0 an
  // illegal start with junk operands is driven in cycle T0+inj.
  task automatic run_op(input logic [1:0] o, input logic [31:0] s, input logic [4:0] sh,
                        input logic [31:0] exp_res, input int unsigned inj);
    int unsigned n;
    exp_t e;
    n = n_steps(sh);
    start = 1'b1; op = o; src = s; shamt = sh;
    e.res = exp_res;
    e.cyc = cyc + 1 + n;
    exp_q.push_back(e);
    @(negedge clk);
    check("busy_t0", busy, 1);
    tick;
    start = 1'b0;
    for (int unsigned k = 1; k <= n; k++) begin
      if (k == inj) begin
        start = 1'b1; op = 2'b00; src = 32'hdeadbeef; shamt = 5'd3;
      end
      @(negedge clk);
      check("busy_run", busy, 1);
      tick;
      start = 1'b0;
    end
    @(negedge clk);
    check("busy_done_low", busy, 0);
    tick;
  endtask

  // Scoreboard monitor: done cycle timing, then result after the edge.
  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        @(posedge clk);
        #1;
        check("result", result, e.res);
      end
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; src = '0; shamt = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    @(negedge clk);
    reset = 1'b1;
    tick;

    run_op(2'b01, 32'hfff0f2f0, 5'd4,  32'h0fff0f2f, 0);
    run_op(2'b11, 32'hfff0f2f0, 5'd31, 32'hffffffff, 0);
    run_op(2'b01, 32'hfff0f2f0, 5'd16, 32'h0000fff0, 0);
    run_op(2'b00, 32'h00000001, 5'd0,  32'h00000001, 0);
    run_op(2'b00, 32'h0000fff0, 5'd15, 32'h7ff80000, 0);
    run_op(2'b10, 32'h00000003, 5'd8,  32'h00000300, 0);
    run_op(2'b11, 32'h7ffffff0, 5'd2,  32'h1ffffffc, 0);

    // Flush in RUN: no pulse, result keeps the previous completion.
    start = 1'b1; op = 2'b11; src = 32'h80000000; shamt = 5'd31;
    @(negedge clk);
    check("flush_busy_t0", busy, 1);
    tick;
    start = 1'b0;
    tick;
    tick;
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_t3", busy, 1);
    tick;
    flush = 1'b0;
    check("flush_busy_t4", busy, 0);
    check("flush_result_kept", result, 32'h1ffffffc);
    run_op(2'b01, 32'h0000005e, 5'd5, 32'h00000002, 0);

    // Flush and start together: flush wins.
    start = 1'b1; flush = 1'b1; op = 2'b01; src = 32'hffffffff; shamt = 5'd1;
    @(negedge clk);
    check("flush_start_busy", busy, 0);
    tick;
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", busy, 0);

    // Illegal start during RUN is ignored.
    run_op(2'b01, 32'h12345678, 5'd12, 32'h00012345, 2);

    // Reset mid-operation: abandoned at once, no pulse.
    start = 1'b1; op = 2'b11; src = 32'h80000000; shamt = 5'd31;
    tick;
    start = 1'b0;
    tick;
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    @(negedge clk);
    reset = 1'b1;
    tick;
    check("midrst_idle", busy, 0);
    run_op(2'b01, 32'hfff0f2f0, 5'd4, 32'h0fff0f2f, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick;
    repeat (3) tick;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
